// File: rtl/perceptron_train_sequencer.sv
// perceptron_train_sequencer: replays a loadable sample table into one Perceptron for E train+eval
// epochs and scores every eval pass by correct-classification count and summed cross-entropy cost.
module perceptron_train_sequencer #(
    parameter int  input_units = 2,
    parameter int  num_samples = 4,
    parameter int  num_epochs  = 100,
    parameter real threshold   = 0.5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               load_en,
    input  logic [$clog2(num_samples)-1:0]     load_addr,
    input  real                                load_values [input_units],
    input  real                                load_expected,
    output real                                values [input_units],
    output logic                               training,
    output real                                error_gradient,
    input  real                                prediction,
    output logic                               busy,
    output logic                               done,
    output logic [31:0]                        epoch,
    output logic [$clog2(num_samples+1)-1:0]   correct,
    output real                                cost_sum
);
    localparam real EPSILON = 1e-7;
    localparam int  AW = $clog2(num_samples);
    localparam int  CW = $clog2(num_samples + 1);

    typedef enum logic [2:0] {IDLE, TR_APPLY, TR_HOLD, EV_APPLY, EV_HOLD, DONE} state_t;

    state_t        r_state, w_next;
    real           r_tab_val [num_samples][input_units];
    real           r_tab_exp [num_samples];
    real           r_hold [input_units];
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_correct_acc;
    real           r_cost_acc;
    logic          w_sampling, w_last, w_hit;
    real           w_e, w_cost;

    assign w_sampling = r_state inside {TR_APPLY, TR_HOLD, EV_APPLY, EV_HOLD};
    assign w_last     = r_idx == AW'(num_samples - 1);
    assign training   = r_state inside {TR_APPLY, TR_HOLD};
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = start ? TR_APPLY : IDLE;
            TR_APPLY: w_next = TR_HOLD;
            TR_HOLD:  w_next = w_last ? EV_APPLY : TR_APPLY;
            EV_APPLY: w_next = EV_HOLD;
            EV_HOLD:  w_next = !w_last ? EV_APPLY : (epoch + 32'd1 == 32'(num_epochs)) ? DONE : TR_APPLY;
            default:  w_next = IDLE;
        endcase
    end

    // Outside the sample states the Perceptron keeps seeing the last sample it was given.
    always_comb begin
        w_e            = r_tab_exp[r_idx];
        w_hit          = (prediction < threshold) == (w_e < threshold);
        w_cost         = -(w_e * $ln(prediction + EPSILON) + (1.0 - w_e) * $ln(1.0 - prediction + EPSILON));
        error_gradient = w_sampling ? -(w_e / (prediction + EPSILON) - (1.0 - w_e) / (1.0 - prediction + EPSILON)) : 0.0;
        for (int i = 0; i < input_units; i++)
            values[i] = w_sampling ? r_tab_val[r_idx][i] : r_hold[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            epoch         <= '0;
            correct       <= '0;
            cost_sum      <= 0.0;
            r_correct_acc <= '0;
            r_cost_acc    <= 0.0;
            for (int n = 0; n < num_samples; n++) begin
                r_tab_exp[n] <= 0.0;
                for (int i = 0; i < input_units; i++)
                    r_tab_val[n][i] <= 0.0;
            end
            for (int i = 0; i < input_units; i++)
                r_hold[i] <= 0.0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && load_en && 32'(load_addr) < 32'(num_samples)) begin
                r_tab_exp[load_addr] <= load_expected;
                for (int i = 0; i < input_units; i++)
                    r_tab_val[load_addr][i] <= load_values[i];
            end
            if (r_state == IDLE && start) begin
                r_idx         <= '0;
                epoch         <= '0;
                r_correct_acc <= '0;
                r_cost_acc    <= 0.0;
            end
            if (w_sampling)
                for (int i = 0; i < input_units; i++)
                    r_hold[i] <= r_tab_val[r_idx][i];
            if (r_state == TR_HOLD || r_state == EV_HOLD)
                r_idx <= w_last ? '0 : r_idx + AW'(1);
            // Final eval sample folds straight into the published results.
            if (r_state == EV_HOLD && w_last) begin
                correct       <= r_correct_acc + CW'(w_hit);
                cost_sum      <= r_cost_acc + w_cost;
                r_correct_acc <= '0;
                r_cost_acc    <= 0.0;
                epoch         <= epoch + 32'd1;
            end else if (r_state == EV_HOLD) begin
                r_correct_acc <= r_correct_acc + CW'(w_hit);
                r_cost_acc    <= r_cost_acc + w_cost;
            end
        end
    end
endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// tb_perceptron_train_sequencer: drives the sequencer with a stub Perceptron (constant or random
// prediction) and checks every cycle against a per-cycle schedule model of the run.
module tb_perceptron_train_sequencer;
    localparam int  U = 2, N = 4, E = 3, L = 4 * N * E;
    localparam real EPS = 1e-7, THR = 0.5;

    typedef struct {
        real e;
        real p;
        real g;
    } vec_t;

    logic        clk = 0, rst = 1, start = 0, load_en = 0;
    logic [1:0]  load_addr = 0;
    real         load_values [U];
    real         load_expected = 0.0;
    real         values [U];
    logic        training, busy, done;
    real         error_gradient, cost_sum;
    real         prediction = 0.0;
    logic [31:0] epoch;
    logic [2:0]  correct;

    int   checks = 0, errors = 0;
    real  m_val [N][U];
    real  m_exp [N];
    int   m_correct = 0, m_epoch = 0;
    real  m_cost = 0.0;
    vec_t vecs [6];

    perceptron_train_sequencer #(.input_units(U), .num_samples(N), .num_epochs(E), .threshold(THR)) dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_addr(load_addr),
        .load_values(load_values), .load_expected(load_expected), .values(values),
        .training(training), .error_gradient(error_gradient), .prediction(prediction),
        .busy(busy), .done(done), .epoch(epoch), .correct(correct), .cost_sum(cost_sum)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1);
    end

    task automatic chk_i(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp, input real tol);
        real d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol * (1.0 + (exp < 0 ? -exp : exp))) begin
            errors++;
            $display("FAIL %s got %f want %f", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk_i({tag, "_busy"}, busy, 0);
        chk_i({tag, "_done"}, done, 0);
        chk_i({tag, "_training"}, training, 0);
        chk_i({tag, "_epoch"}, epoch, 0);
        chk_i({tag, "_correct"}, correct, 0);
        chk_r({tag, "_cost"}, cost_sum, 0.0, 0.0);
        chk_r({tag, "_grad"}, error_gradient, 0.0, 0.0);
        for (int u = 0; u < U; u++)
            chk_r({tag, "_values"}, values[u], 0.0, 0.0);
    endtask

    function automatic real grad_of(input real e, input real p);
        return -(e / (p + EPS) - (1.0 - e) / (1.0 - p + EPS));
    endfunction

    task automatic load(input int a, input real v0, input real v1, input real e);
        @(negedge clk);
        start = 0;
        load_en = 1;
        load_addr = 2'(a);
        load_values[0] = v0;
        load_values[1] = v1;
        load_expected = e;
        m_val[a][0] = v0;
        m_val[a][1] = v1;
        m_exp[a] = e;
    endtask

    task automatic idle();
        @(negedge clk);
        start = 0;
        load_en = 0;
    endtask

    // Call right after a negedge: the start edge k follows; cycle j is the j-th cycle after k.
    task automatic run(input bit rnd, input real cp, input bit vec, input int inj_j, input int abort_j);
        int  acc_c, w, s;
        real acc_cost, p;
        bit  tr, hold;
        acc_c = 0;
        acc_cost = 0.0;
        m_epoch = 0;
        start = 1;
        for (int j = 1; j <= L + 2; j++) begin
            @(negedge clk);
            start = 0;
            load_en = 0;
            p = rnd ? real'($urandom_range(10, 990)) / 1000.0 : cp;
            if (j == inj_j) begin
                start = 1;
                load_en = 1;
                load_addr = 0;
                load_values[0] = 5.0;
                load_values[1] = 5.0;
                load_expected = 1.0;
            end
            if (j > L) begin
                prediction = p;
                #1;
                chk_i("done", done, (j == L + 1) ? 1 : 0);
                chk_i("busy", busy, (j == L + 1) ? 1 : 0);
                chk_i("training", training, 0);
                chk_r("grad_idle", error_gradient, 0.0, 0.0);
                for (int u = 0; u < U; u++)
                    chk_r("values_held", values[u], m_val[N-1][u], 0.0);
                chk_i("epoch_end", epoch, E);
                chk_i("correct", correct, m_correct);
                chk_r("cost_sum", cost_sum, m_cost, 1e-9);
            end else begin
                w = (j - 1) % (4 * N);
                tr = w < 2 * N;
                s = (w % (2 * N)) / 2;
                hold = (w % 2) == 1;
                if (vec && j <= 2 * N)
                    for (int v = 0; v < 6; v++)
                        if (vecs[v].e == m_exp[s]) begin
                            prediction = vecs[v].p;
                            #1;
                            chk_r("grad_vec", error_gradient, vecs[v].g, 1e-5);
                        end
                prediction = p;
                #1;
                chk_i("training", training, tr);
                chk_i("busy", busy, 1);
                chk_i("done", done, 0);
                for (int u = 0; u < U; u++)
                    chk_r("values", values[u], m_val[s][u], 0.0);
                chk_r("grad", error_gradient, grad_of(m_exp[s], p), 1e-9);
                chk_i("epoch", epoch, m_epoch);
                chk_i("correct", correct, m_correct);
                chk_r("cost_sum", cost_sum, m_cost, 1e-9);
                if (!tr && hold) begin
                    acc_c += ((p < THR) == (m_exp[s] < THR)) ? 1 : 0;
                    acc_cost += -(m_exp[s] * $ln(p + EPS) + (1.0 - m_exp[s]) * $ln(1.0 - p + EPS));
                    if (s == N - 1) begin
                        m_correct = acc_c;
                        m_cost = acc_cost;
                        m_epoch++;
                        acc_c = 0;
                        acc_cost = 0.0;
                    end
                end
                if (j == abort_j) begin
                    #2 rst = 0;
                    #1 chk_reset("abort");
                    for (int a = 0; a < N; a++) begin
                        m_exp[a] = 0.0;
                        for (int u = 0; u < U; u++) m_val[a][u] = 0.0;
                    end
                    m_correct = 0;
                    m_cost = 0.0;
                    m_epoch = 0;
                    @(negedge clk);
                    rst = 1;
                    return;
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{1.0, 0.25, -4.0};
        vecs[1] = '{0.0, 0.25, 1.3333333};
        vecs[2] = '{1.0, 0.5, -2.0};
        vecs[3] = '{0.0, 0.5, 2.0};
        vecs[4] = '{1.0, 0.8, -1.25};
        vecs[5] = '{0.0, 0.8, 5.0};
        for (int a = 0; a < N; a++) begin
            m_exp[a] = 0.0;
            for (int u = 0; u < U; u++) m_val[a][u] = 0.0;
        end
        #1 rst = 0;
        #1 chk_reset("reset");
        @(negedge clk);
        rst = 1;

        load(0, 0.0, 0.0, 0.0);
        load(1, 0.0, 1.0, 0.0);
        load(2, 1.0, 0.0, 0.0);
        load(3, 1.0, 1.0, 1.0);
        run(0, 0.2, 1, 0, 0);
        chk_i("and_correct", correct, 3);
        chk_r("and_cost", cost_sum, 2.2789, 1e-4);
        chk_i("and_epoch", epoch, E);

        idle();
        run(1, 0.0, 0, 5, 0);
        idle();
        run(1, 0.0, 0, 0, 0);

        for (int a = 0; a < N; a++)
            load(a, real'($urandom_range(0, 1000)) / 100.0, real'($urandom_range(0, 1000)) / 100.0,
                 real'($urandom_range(0, 1)));
        idle();
        run(1, 0.0, 0, 0, 0);

        idle();
        run(1, 0.0, 0, 0, 4 * N + 2 * N + 3);
        load(0, 0.0, 0.0, 0.0);
        load(1, 0.0, 1.0, 0.0);
        load(2, 1.0, 0.0, 0.0);
        load(3, 1.0, 1.0, 1.0);
        idle();
        run(0, 0.2, 0, 0, 0);
        chk_i("fresh_correct", correct, 3);
        chk_i("fresh_epoch", epoch, E);

        @(negedge clk);
        prediction = 0.25;
        #1 chk_r("idle_grad", error_gradient, 0.0, 0.0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
